// File: rtl/locked_adder_error_profiler.sv
// rtl/locked_adder_error_profiler.sv - key-sweep error profiler for an external locked adder
module locked_adder_error_profiler #(
  parameter int WIDTH      = 16,
  parameter int KEY_W      = 32,
  parameter int NPAIRS_MAX = 5000,
  parameter int NKEYS      = 16,
  parameter int LAT        = 1,
  parameter int CNT_W      = 24,
  localparam int PA_W = (NPAIRS_MAX > 1) ? $clog2(NPAIRS_MAX) : 1,
  localparam int KI_W = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_we_i,
  input  logic [PA_W-1:0]  op_addr_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             key_we_i,
  input  logic [KI_W-1:0]  key_addr_i,
  input  logic [KEY_W-1:0] key_data_i,
  input  logic             start_i,
  input  logic [PA_W:0]    num_pairs_i,
  input  logic [KI_W:0]    num_keys_i,
  output logic [WIDTH-1:0] dut_a_o,
  output logic [WIDTH-1:0] dut_b_o,
  output logic [KEY_W-1:0] dut_key_o,
  input  logic [WIDTH:0]   dut_result_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [KI_W-1:0]  rd_idx_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  // with a combinational adder there is nothing in flight, so DRAIN is skipped
  localparam logic [2:0] S_POST  = (LAT == 0) ? S_NEXT : S_DRAIN;

  localparam int PC_W  = $clog2(WIDTH + 2);
  localparam int SUM_W = CNT_W + PC_W;
  localparam int DC_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [PA_W:0]    NP_MAX  = (PA_W + 1)'(NPAIRS_MAX);
  localparam logic [KI_W:0]    NK_MAX  = (KI_W + 1)'(NKEYS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]         state;
  logic [PA_W:0]      np_q;
  logic [KI_W:0]      nk_q;
  logic [PA_W-1:0]    p_q;
  logic [KI_W-1:0]    k_q;
  logic [DC_W-1:0]    dcnt_q;
  logic [2*WIDTH-1:0] op_mem  [NPAIRS_MAX];
  logic [KEY_W-1:0]   key_mem [NKEYS];
  logic [CNT_W-1:0]   err_mem [NKEYS];
  logic [CNT_W-1:0]   bit_mem [NKEYS];

  logic [PA_W:0] np_clamp;
  logic [KI_W:0] nk_clamp;
  logic          start_ok;
  logic          last_pair;
  logic          last_key;

  assign np_clamp  = (num_pairs_i > NP_MAX) ? NP_MAX : num_pairs_i;
  assign nk_clamp  = (num_keys_i > NK_MAX) ? NK_MAX : num_keys_i;
  assign start_ok  = (state == S_IDLE) && start_i;
  assign last_pair = ({1'b0, p_q} == (np_q - 1'b1));
  assign last_key  = (({1'b0, k_q} + 1'b1) == nk_q);
  assign busy_o    = (state == S_LOAD) || (state == S_ISSUE) ||
                     (state == S_DRAIN) || (state == S_NEXT);
  assign done_o    = (state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (op_we_i && !busy_o && ({1'b0, op_addr_i} < NP_MAX))
      op_mem[op_addr_i] <= {op_a_i, op_b_i};
    if (key_we_i && !busy_o && ({1'b0, key_addr_i} < NK_MAX))
      key_mem[key_addr_i] <= key_data_i;
  end

  // dut_key_o is loaded on entry to LOAD so it already shows the new key there
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      np_q      <= '0;
      nk_q      <= '0;
      p_q       <= '0;
      k_q       <= '0;
      dcnt_q    <= '0;
      dut_key_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            np_q <= np_clamp;
            nk_q <= nk_clamp;
            k_q  <= '0;
            if (nk_clamp == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_LOAD;
              dut_key_o <= key_mem[0];
            end
          end
        end
        S_LOAD: begin
          p_q    <= '0;
          dcnt_q <= '0;
          state  <= (np_q == '0) ? S_POST : S_ISSUE;
        end
        S_ISSUE: begin
          p_q <= p_q + 1'b1;
          if (last_pair) state <= S_POST;
        end
        S_DRAIN: begin
          if (dcnt_q == DC_LAST) state <= S_NEXT;
          else dcnt_q <= dcnt_q + 1'b1;
        end
        S_NEXT: begin
          if (last_key) begin
            state <= S_DONE;
          end else begin
            k_q       <= k_q + 1'b1;
            dut_key_o <= key_mem[k_q + 1'b1];
            state     <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic            v0;
  logic [KI_W-1:0] k0;
  logic [WIDTH:0]  golden0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dut_a_o <= '0;
      dut_b_o <= '0;
      v0      <= 1'b0;
      k0      <= '0;
    end else begin
      v0 <= (state == S_ISSUE);
      k0 <= k_q;
      if (state == S_ISSUE) {dut_a_o, dut_b_o} <= op_mem[p_q];
    end
  end

  assign golden0 = {1'b0, dut_a_o} + {1'b0, dut_b_o};

  logic            v_ret;
  logic [WIDTH:0]  g_ret;
  logic [KI_W-1:0] k_ret;

  // stage 0 is aligned with dut_a_o/dut_b_o; the retiring stage lines up with dut_result_i
  if (LAT == 0) begin : g_nodl
    assign v_ret = v0;
    assign g_ret = golden0;
    assign k_ret = k0;
  end else begin : g_dl
    logic            v_d [LAT];
    logic [WIDTH:0]  g_d [LAT];
    logic [KI_W-1:0] k_d [LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < LAT; i++) begin
          v_d[i] <= 1'b0;
          g_d[i] <= '0;
          k_d[i] <= '0;
        end
      end else begin
        v_d[0] <= v0;
        g_d[0] <= golden0;
        k_d[0] <= k0;
        for (int i = 1; i < LAT; i++) begin
          v_d[i] <= v_d[i-1];
          g_d[i] <= g_d[i-1];
          k_d[i] <= k_d[i-1];
        end
      end
    end

    assign v_ret = v_d[LAT-1];
    assign g_ret = g_d[LAT-1];
    assign k_ret = k_d[LAT-1];
  end

  logic [WIDTH:0]     x;
  logic [PC_W-1:0]    pc;
  logic [CNT_W:0]     err_sum;
  logic [SUM_W-1:0]   bit_sum;
  logic [CNT_W-1:0]   err_nxt;
  logic [CNT_W-1:0]   bit_nxt;

  assign x = g_ret ^ dut_result_i;

  always_comb begin
    pc = '0;
    for (int i = 0; i <= WIDTH; i++) pc = pc + {{(PC_W-1){1'b0}}, x[i]};
  end

  assign err_sum = {1'b0, err_mem[k_ret]} + {{CNT_W{1'b0}}, (x != '0)};
  assign bit_sum = {{PC_W{1'b0}}, bit_mem[k_ret]} + {{CNT_W{1'b0}}, pc};
  assign err_nxt = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
  assign bit_nxt = (|bit_sum[SUM_W-1:CNT_W]) ? CNT_MAX : bit_sum[CNT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NKEYS; i++) begin
        err_mem[i] <= '0;
        bit_mem[i] <= '0;
      end
    end else if (start_ok) begin
      for (int i = 0; i < NKEYS; i++) begin
        err_mem[i] <= '0;
        bit_mem[i] <= '0;
      end
    end else if (v_ret) begin
      err_mem[k_ret] <= err_nxt;
      bit_mem[k_ret] <= bit_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end else if ({1'b0, rd_idx_i} < NK_MAX) begin
      err_cnt_o <= err_mem[rd_idx_i];
      bit_cnt_o <= bit_mem[rd_idx_i];
    end else begin
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end
  end

endmodule
